// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants.
// The 64-bit fetch entry carries the PC alongside its instruction word.
package cpu_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry FIFO with flush. Head is read combinationally, so a write is visible one cycle later.
// Backpressure: a push while full is dropped unless a pop happens on the same edge.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/fetch_queue.sv
// IF stage: PC register feeding a prefetch FIFO; fetched words reach out_* one cycle later.
// Backpressure: out_ready low stalls the queue; when full the PC holds. redirect flushes and reloads.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          IM_ADDR_W = 7,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic [IM_ADDR_W-1:0]       im_addr,
  input  logic [31:0]                im_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pcplus4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                fetch_pc
);

  logic [31:0]  pc;
  fetch_entry_t head;
  fetch_entry_t wentry;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready && !redirect;
  assign push      = fetch_en && !redirect && (!full || pop);

  assign wentry.pc   = pc;
  assign wentry.inst = im_rdata;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // im_addr comes only from the PC register, keeping out_ready off the memory address path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc <= RESET_PC;
    else if (redirect) pc <= {redirect_pc[31:2], 2'b00};
    else if (push)     pc <= pc + PC_STEP;
  end

  assign im_addr  = pc[IM_ADDR_W+1:2];
  assign fetch_pc = pc;

  // Empty queue presents a NOP bubble to decode.
  assign out_inst    = out_valid ? head.inst : NOP_INST;
  assign out_pc      = out_valid ? head.pc : 32'h0;
  assign out_pcplus4 = out_valid ? head.pc + PC_STEP : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a reference model and {pc,inst} scoreboard.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int IMW   = 7;
  localparam int CW    = $clog2(DEPTH+1);

  logic           clk;
  logic           rst;
  logic           fetch_en;
  logic [IMW-1:0] im_addr;
  logic [31:0]    im_rdata;
  logic           redirect;
  logic [31:0]    redirect_pc;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_inst;
  logic [31:0]    out_pc;
  logic [31:0]    out_pcplus4;
  logic [CW-1:0]  count;
  logic [31:0]    fetch_pc;

  logic [31:0] imem [2**IMW];
  assign im_rdata = imem[im_addr];

  fetch_queue #(.DEPTH(DEPTH), .IM_ADDR_W(IMW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .im_addr(im_addr), .im_rdata(im_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_pcplus4(out_pcplus4), .count(count), .fetch_pc(fetch_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb [$];
  int          m_count;
  logic [31:0] m_pc;
  bit          order_en;
  int          order_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; checks, advances the model, waits one cycle.
  task automatic cycle();
    logic        p;
    logic        q;
    logic [63:0] h;
    logic [31:0] rpc;
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("out_valid", 32'(out_valid), 32'(m_count != 0));
    chk("fetch_pc", fetch_pc, m_pc);
    chk("im_addr", 32'(im_addr), 32'(m_pc[IMW+1:2]));
    if (m_count != 0) begin
      h = sb[0];
      chk("out_pc", out_pc, h[63:32]);
      chk("out_inst", out_inst, h[31:0]);
      chk("out_pcplus4", out_pcplus4, h[63:32] + 32'd4);
    end else begin
      chk("out_pc_empty", out_pc, 32'h0);
      chk("out_inst_empty", out_inst, 32'h0);
      chk("out_pcplus4_empty", out_pcplus4, 32'h0);
    end
    p = (m_count != 0) && out_ready && !redirect;
    q = fetch_en && !redirect && ((m_count < DEPTH) || p);
    if (order_en && p && order_k < 10) begin
      chk("wrap_order", out_inst, 32'h1000_0000 + 32'(order_k));
      order_k++;
    end
    if (redirect) begin
      sb.delete();
      m_count = 0;
      rpc = redirect_pc;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (p) begin
        void'(sb.pop_front());
        m_count--;
      end
      if (q) begin
        sb.push_back({m_pc, imem[m_pc[IMW+1:2]]});
        m_count++;
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic fe, input logic rdy, input logic rd, input logic [31:0] rpc);
    fetch_en = fe;
    out_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
  endtask

  initial begin
    for (int k = 0; k < 2**IMW; k++) imem[k] = 32'h1000_0000 + 32'(k);
    order_en = 1'b0;
    order_k = 0;
    m_count = 0;
    m_pc = 32'h0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_pcplus4", out_pcplus4, 32'h0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);

    // Fill with ID stalled.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (6) cycle();
    chk("fill_fetch_pc", fetch_pc, 32'h10);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_out_pc", out_pc, 32'h0);

    // Full queue with simultaneous push/pop.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) cycle();
    chk("stream_count", 32'(count), 32'd4);
    chk("stream_fetch_pc", fetch_pc, 32'h1C);

    drive(1'b0, 1'b1, 1'b0, 32'h0);
    cycle();
    chk("pre_redirect_count", 32'(count), 32'd3);

    drive(1'b1, 1'b1, 1'b1, 32'h0000_0043);
    cycle();
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_inst", out_inst, 32'h0);
    chk("redir_fetch_pc", fetch_pc, 32'h40);

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("redir_out_pc", out_pc, 32'h40);
    chk("redir_pcplus4", out_pcplus4, 32'h44);
    repeat (2) cycle();

    // Drain with fetch disabled.
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) cycle();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_inst", out_inst, 32'h0);
    chk("drain_fetch_pc", fetch_pc, 32'h4C);
    cycle();

    // Mid-cycle asynchronous reset with two entries queued.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) cycle();
    chk("pre_rst_count", 32'(count), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_fetch_pc", fetch_pc, 32'h0);
    #1 rst = 1'b0;
    sb.delete();
    m_count = 0;
    m_pc = 32'h0;
    @(negedge clk);

    // Streaming across pointer wrap.
    order_en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (12) cycle();
    order_en = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch stage with a prefetch buffer; next generation of the pipeline IF stage.
- Owns the PC, drives the instruction-memory address, and pushes {pc, inst} pairs into a DEPTH-entry FIFO.
- The ID stage consumes from the FIFO through a valid/ready handshake.
- A redirect (branch/jump resolved in ID) flushes the buffer and reloads the PC, replacing the PCWrite/ifid_write/flush wiring used so far.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- IM_ADDR_W, 7, instruction-memory word-address width; im_addr = pc[IM_ADDR_W+1:2].
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_en  in  1  global fetch enable; when low, no push and the PC holds.
- im_addr  out  IM_ADDR_W  combinational word address into instruction memory, equal to pc[IM_ADDR_W+1:2].
- im_rdata  in  32  instruction returned combinationally in the same cycle.
- redirect  in  1  branch/jump taken; flush the queue and load redirect_pc.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  ID accepts the head this cycle; low means ID stall.
- out_inst  out  32  head instruction; 32'h0 when empty.
- out_pc  out  32  head PC; 32'h0 when empty.
- out_pcplus4  out  32  out_pc + 4; 32'h0 when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.
- fetch_pc  out  32  current PC register, for debug.

Behaviour:
Reset:
- pc = RESET_PC; read/write pointers = 0; count = 0.
- out_valid = 0; out_inst, out_pc and out_pcplus4 = 0.
- Reset asserted mid-operation discards all entries immediately (asynchronously).

Per-cycle definitions:
- pop = out_valid && out_ready && !redirect.
- push = fetch_en && !redirect && (count < DEPTH || pop).

Priority, decided per edge:
1. redirect:
   - count <= 0 and pointers <= 0; pc <= {redirect_pc[31:2], 2'b00}.
   - No push and no pop that cycle, even if out_ready is high.
   - The instruction at im_rdata is dropped.
2. push:
   - Entry {pc, im_rdata} is written at the write pointer.
   - The write pointer advances modulo DEPTH; pc <= pc + 4, wrapping at 2^32.
3. pop:
   - The read pointer advances modulo DEPTH.

Count and occupancy rules:
- count updates by +push − pop.
- Full with simultaneous pop: push is allowed and count stays at DEPTH.
- Full without pop: the PC holds and im_addr is unchanged.
- Empty with out_ready high: nothing happens.

Output timing:
- Outputs present the head entry combinationally from the FIFO storage.
- Latency is 1 cycle: an instruction fetched in cycle N is visible on out_* in cycle N+1.
- There is no bypass from im_rdata to out_*.
- out_valid = (count != 0).
- An empty queue presents 32'h0 (NOP) so the downstream control decodes a bubble.

Other rules:
- fetch_en low with redirect high: the redirect is still applied.
- The ID stall is fully absorbed by out_ready; no combinational path from out_ready to im_addr.

Decomposition:
- Shared package (cpu_pkg) holds:
  - NOP_INST = 32'h0000_0000
  - PC_STEP = 4
  - a 64-bit fetch-entry typedef {pc[31:0], inst[31:0]}
- One natural sub-module, fetch_fifo:
  - parametrised width and DEPTH, synchronous push/pop, flush input, async active-high reset.
  - outputs head data, count, full and empty.
- fetch_queue wraps fetch_fifo with the PC register, push/pop arbitration and output zeroing.

Test Plan:
- Reset, then fetch_en=1, out_ready=0, 6 cycles:
  - count goes 1,2,3,4,4,4.
  - fetch_pc stops at 32'h10.
  - out_pc stays 0x0 with out_valid=1 throughout.
- Queue full (DEPTH=4), out_ready=1 for 3 cycles:
  - out_pc goes 0x0, 0x4, 0x8; count stays 4.
  - Pushes of 0x10, 0x14, 0x18 occur.
- Redirect with redirect_pc=32'h0000_0043 while count=3 and out_ready=1:
  - Next cycle count=0, out_valid=0, out_inst=0, fetch_pc=32'h40.
  - The following cycle out_pc=32'h40 and out_pcplus4=32'h44.
- fetch_en=0 for 3 cycles with out_ready=1:
  - The queue drains to 0 and fetch_pc is constant.
  - After draining, out_inst=0.
- Assert rst for 2 ns mid-cycle with count=2:
  - count, out_valid and out_pc go to 0 before the next clock edge.
  - fetch_pc=RESET_PC.
- Pointer wrap: run 10 push/pop cycles with out_ready=1 and check instruction order.
  - Preload IM word k = 32'h1000_0000+k.
  - out_inst sequence is 32'h1000_0000…32'h1000_0009 with no duplicates or gaps.
